// File: rtl/shift_seq_unit.sv
// Sequential shift/rotate unit: one single-bit step per cycle under an IDLE/SHIFT/DONE FSM.
// Optional carry output is enabled by defining SHIFT_CARRY_EN.
module shift_seq_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [1:0] s,
    input  logic [2:0] amt,
    output logic [7:0] reg_out,
    output logic       busy,
    output logic       done
`ifdef SHIFT_CARRY_EN
    ,
    output logic       carry
`endif
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    count, count_next;
    logic [1:0]          op, op_next;
    logic [DATA_W-1:0]   reg_next;
    logic                busy_next, done_next;
`ifdef SHIFT_CARRY_EN
    logic                carry_next;
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            op      <= '0;
            reg_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SHIFT_CARRY_EN
            carry   <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            count   <= count_next;
            op      <= op_next;
            reg_out <= reg_next;
            busy    <= busy_next;
            done    <= done_next;
`ifdef SHIFT_CARRY_EN
            carry   <= carry_next;
`endif
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_next = state;
        count_next = count;
        op_next    = op;
        reg_next   = reg_out;
`ifdef SHIFT_CARRY_EN
        carry_next = carry;
`endif
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    reg_next   = A;
                    op_next    = s;
                    count_next = amt;
`ifdef SHIFT_CARRY_EN
                    carry_next = 1'b0;
`endif
                    state_next = (amt != CNT_W'(0)) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                case (op)
                    2'b00:   reg_next = {reg_out[0], reg_out[DATA_W-1:1]};
                    2'b01:   reg_next = {1'b0, reg_out[DATA_W-1:1]};
                    2'b10:   reg_next = {reg_out[DATA_W-2:0], reg_out[DATA_W-1]};
                    default: reg_next = {reg_out[DATA_W-2:0], 1'b0};
                endcase
`ifdef SHIFT_CARRY_EN
                carry_next = op[1] ? reg_out[DATA_W-1] : reg_out[0];
`endif
                count_next = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next == SHIFT);
        done_next = (state_next == DONE);
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Testbench for shift_seq_unit: directed vectors plus randomized operations against a closed-form model.
// Carry checks are compiled in when SHIFT_CARRY_EN is defined.
module tb_shift_seq_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [1:0] s;
    logic [2:0] amt;
    logic [7:0] reg_out;
    logic       busy;
    logic       done;
`ifdef SHIFT_CARRY_EN
    logic       carry;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_seq_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (A),
        .s       (s),
        .amt     (amt),
        .reg_out (reg_out),
        .busy    (busy),
        .done    (done)
`ifdef SHIFT_CARRY_EN
        ,
        .carry   (carry)
`endif
    );

    // Result of the whole operation computed in one go from the operand
    function automatic logic [7:0] ref_res(input logic [7:0] a, input logic [1:0] op, input int k);
        logic [15:0] d;
        d = {a, a};
        case (op)
            2'd0:    d = d >> k;
            2'd1:    d = {8'h00, a} >> k;
            2'd2:    d = (d << k) >> 8;
            default: d = {8'h00, a} << k;
        endcase
        return d[7:0];
    endfunction

    // Last bit to leave the operand: bit k-1 going right, bit 8-k going left
    function automatic logic ref_carry(input logic [7:0] a, input logic [1:0] op, input int k);
        logic [7:0] t;
        if (k == 0) return 1'b0;
        t = op[1] ? (a >> (8 - k)) : (a >> (k - 1));
        return t[0];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [1:0] sv, input logic [2:0] k);
        A     = a;
        s     = sv;
        amt   = k;
        start = 1'b1;
    endtask

    // Follows one accepted operation sample by sample; optionally chains the next start in DONE
    task automatic run(input logic [7:0] a, input logic [1:0] sv, input logic [2:0] k,
                       input bit junk, input bit chain,
                       input logic [7:0] na, input logic [1:0] ns, input logic [2:0] nk);
        logic [7:0] er;
        logic       ec;
        er = ref_res(a, sv, int'(k));
        ec = ref_carry(a, sv, int'(k));
        @(posedge clk); #1;
        for (int i = 0; i <= int'(k); i++) begin
            check("busy", {7'b0, busy}, {7'b0, (i < int'(k))});
            check("done", {7'b0, done}, {7'b0, (i == int'(k))});
            if (i < int'(k)) begin
                if (junk) begin
                    A     = 8'($urandom);
                    s     = 2'($urandom);
                    amt   = 3'($urandom);
                    start = 1'($urandom_range(0, 1));
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        check("result", reg_out, er);
`ifdef SHIFT_CARRY_EN
        check("carry", {7'b0, carry}, {7'b0, ec});
`endif
        if (chain) begin
            issue(na, ns, nk);
        end else begin
            start = 1'b0;
            if (junk) begin
                A   = 8'($urandom);
                s   = 2'($urandom);
                amt = 3'($urandom);
            end
            @(posedge clk); #1;
            check("idle_done", {7'b0, done}, 8'h00);
            check("idle_busy", {7'b0, busy}, 8'h00);
            check("hold_result", reg_out, er);
`ifdef SHIFT_CARRY_EN
            check("hold_carry", {7'b0, carry}, {7'b0, ec});
`endif
        end
    endtask

    initial begin
        logic [7:0] ca, na, orig;
        logic [1:0] cs, ns;
        logic [2:0] ck, nk;
        bit         nxt;

        rst = 1'b1; start = 1'b0; A = '0; s = '0; amt = '0;
        #2;
        check("rst_reg", reg_out, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        check("rst_done", {7'b0, done}, 8'h00);
`ifdef SHIFT_CARRY_EN
        check("rst_carry", {7'b0, carry}, 8'h00);
`endif
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        issue(8'hAE, 2'b00, 3'd1); run(8'hAE, 2'b00, 3'd1, 0, 0, 8'h0, 2'b0, 3'd0);
        issue(8'hAE, 2'b01, 3'd3); run(8'hAE, 2'b01, 3'd3, 0, 0, 8'h0, 2'b0, 3'd0);
        issue(8'hAE, 2'b10, 3'd4); run(8'hAE, 2'b10, 3'd4, 0, 1, 8'hAE, 2'b11, 3'd7);
        run(8'hAE, 2'b11, 3'd7, 0, 0, 8'h0, 2'b0, 3'd0);
        issue(8'h5A, 2'b11, 3'd0); run(8'h5A, 2'b11, 3'd0, 0, 0, 8'h0, 2'b0, 3'd0);
        orig = 8'($urandom);
        issue(orig, 2'b00, 3'd7); run(orig, 2'b00, 3'd7, 1, 0, 8'h0, 2'b0, 3'd0);

        // Asynchronous reset in the middle of an operation
        issue(8'hC3, 2'b10, 3'd7);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("mid_rst_reg", reg_out, 8'h00);
        check("mid_rst_busy", {7'b0, busy}, 8'h00);
        check("mid_rst_done", {7'b0, done}, 8'h00);
`ifdef SHIFT_CARRY_EN
        check("mid_rst_carry", {7'b0, carry}, 8'h00);
`endif
        @(posedge clk); #1;
        check("rst_hold_reg", reg_out, 8'h00);
        #3 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("post_rst_done", {7'b0, done}, 8'h00);
            check("post_rst_busy", {7'b0, busy}, 8'h00);
        end
        issue(8'h96, 2'b01, 3'd5); run(8'h96, 2'b01, 3'd5, 0, 0, 8'h0, 2'b0, 3'd0);

        // Randomized operations, some chained back-to-back, with junk inputs during SHIFT
        ca = 8'($urandom); cs = 2'($urandom); ck = 3'($urandom);
        issue(ca, cs, ck);
        for (int t = 0; t < 40; t++) begin
            na  = 8'($urandom); ns = 2'($urandom); nk = 3'($urandom);
            nxt = (t < 39) && ($urandom_range(0, 1) == 1);
            run(ca, cs, ck, 1'($urandom_range(0, 1)), nxt, na, ns, nk);
            if (!nxt && t < 39) issue(na, ns, nk);
            ca = na; cs = ns; ck = nk;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
